// File: rtl/s2_rr_sched.sv
// Round-robin scheduler sharing one s2 registered 4:1 select cell among four requesters.
// Drives the s2 select/clear pins and hands the s2 output downstream via valid/ready.
//
// state | meaning
// IDLE  | no grant, s2 held clear, arbitrating req starting at ptr
// LOAD  | grant and select driven, s2 captures D_k at the end of the cycle
// VALID | s2 word presented downstream, waiting for out_ready
module s2_rr_sched #(
   parameter int MAX_BURST = 4,
   parameter int CW        = 4
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [3:0] done,
   output logic       A1,
   output logic       B1,
   output logic       A0,
   output logic       B0,
   output logic       s2_clr,
   output logic       out_valid,
   input  logic       out_ready
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, VALID = 2'd2} state_t;

   localparam logic [CW:0] BURST_MAX = (CW+1)'(MAX_BURST);

   state_t        state;
   logic [1:0]    ptr;
   logic [1:0]    idx;
   logic [CW-1:0] burst_cnt;
   logic [2:0]    arb_idle;
   logic [2:0]    arb_rot;
   logic          accept;
   logic          cont;
   logic          load_new;
   logic [1:0]    new_k;

   // Returns {found, index}: first set request scanning p, p+1, ... mod 4.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] c;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         c = p + 2'(i);
         if (r[c]) res = {1'b1, c};
      end
      return res;
   endfunction

   always_comb begin
      arb_idle = rr_pick(req, ptr);
      arb_rot  = rr_pick(req, idx + 2'd1);
      accept   = (state == VALID) && out_ready;
      cont     = req[idx] && (({1'b0, burst_cnt} + (CW+1)'(1)) < BURST_MAX);
      load_new = ((state == IDLE) && arb_idle[2]) || (accept && !cont && arb_rot[2]);
      new_k    = (state == IDLE) ? arb_idle[1:0] : arb_rot[1:0];
   end

   assign done = accept ? gnt : 4'b0000;
   assign B1   = 1'b0;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         gnt       <= 4'b0000;
         A1        <= 1'b0;
         A0        <= 1'b0;
         B0        <= 1'b0;
         s2_clr    <= 1'b1;
         out_valid <= 1'b0;
         ptr       <= 2'd0;
         idx       <= 2'd0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (load_new) state <= LOAD;
            LOAD: begin
               state     <= VALID;
               out_valid <= 1'b1;
            end
            VALID: if (accept) begin
               out_valid <= 1'b0;
               if (cont) begin
                  burst_cnt <= burst_cnt + CW'(1);
                  state     <= LOAD;
               end else begin
                  ptr   <= idx + 2'd1;
                  state <= load_new ? LOAD : IDLE;
                  if (!load_new) begin
                     gnt    <= 4'b0000;
                     A1     <= 1'b0;
                     A0     <= 1'b0;
                     B0     <= 1'b0;
                     s2_clr <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
         // A fresh grant (from IDLE or on rotation) restarts the burst count.
         if (load_new) begin
            idx       <= new_k;
            gnt       <= 4'b0001 << new_k;
            A1        <= new_k[1];
            A0        <= new_k[0];
            B0        <= new_k[0];
            s2_clr    <= 1'b0;
            burst_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_s2_rr_sched.sv
// Bench for s2_rr_sched: two instances (MAX_BURST=4 and MAX_BURST=1), a behavioural s2 cell
// per instance, and a scoreboard of expected (requester, word) pairs checked on each done.
module tb_s2_rr_sched;

   logic       clk = 1'b0;
   logic       clr_n = 1'b1;
   logic [3:0] req [2];
   logic       out_ready [2];
   logic [3:0] gnt [2];
   logic [3:0] done [2];
   logic       A1 [2];
   logic       B1 [2];
   logic       A0 [2];
   logic       B0 [2];
   logic       s2_clr [2];
   logic       out_valid [2];

   always #5 clk = ~clk;

   s2_rr_sched #(.MAX_BURST(4), .CW(4)) dut_b4 (
      .clk(clk), .clr_n(clr_n), .req(req[0]), .gnt(gnt[0]), .done(done[0]),
      .A1(A1[0]), .B1(B1[0]), .A0(A0[0]), .B0(B0[0]), .s2_clr(s2_clr[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]));

   s2_rr_sched #(.MAX_BURST(1), .CW(4)) dut_b1 (
      .clk(clk), .clr_n(clr_n), .req(req[1]), .gnt(gnt[1]), .done(done[1]),
      .A1(A1[1]), .B1(B1[1]), .A0(A0[1]), .B0(B0[1]), .s2_clr(s2_clr[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]));

   logic [7:0] base [4] = '{8'h11, 8'h3C, 8'hA5, 8'hE7};
   int         wn [2][4];
   int         en [2][4];
   logic [7:0] s2q [2];
   int         qu0 [$];
   int         qu1 [$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         last_done [2];
   bit         gap_on [2];

   function automatic logic [7:0] wdat(input int k, input int n);
      return base[k] + 8'(n * 9);
   endfunction

   function automatic int s2_sel(input int u);
      return {30'd0, A1[u] | B1[u], A0[u] & B0[u]};
   endfunction

   function automatic int qsize(input int u);
      return (u == 0) ? qu0.size() : qu1.size();
   endfunction

   function automatic int qpop(input int u);
      if (u == 0) return qu0.pop_front();
      return qu1.pop_front();
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int u, input int k);
      int e;
      e = k * 256 + int'(wdat(k, en[u][k]));
      en[u][k]++;
      if (u == 0) qu0.push_back(e);
      else qu1.push_back(e);
   endtask

   // External s2 cell: synchronous clear, registered 4:1 mux of the requester data words.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++)
         s2q[u] <= s2_clr[u] ? 8'h00 : wdat(s2_sel(u), wn[u][s2_sel(u)]);
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic mon(input int u);
      int e;
      if (!clr_n) begin
         for (int k = 0; k < 4; k++) wn[u][k] = 0;
         last_done[u] = -1;
      end else if (done[u] != 4'b0000) begin
         if (qsize(u) == 0) begin
            chk("unexpected_done", {28'd0, done[u]}, 32'd0);
         end else begin
            e = qpop(u);
            chk("done_idx", {28'd0, done[u]}, {28'd0, 4'(1 << (e / 256))});
            chk("gnt_at_done", {28'd0, gnt[u]}, {28'd0, 4'(1 << (e / 256))});
            chk("word", {24'd0, s2q[u]}, 32'(e % 256));
            if (gap_on[u] && last_done[u] >= 0) chk("done_gap", 32'(cyc - last_done[u]), 32'd2);
            last_done[u] = cyc;
         end
         // Requester presents its next word once the current one is accepted.
         for (int k = 0; k < 4; k++) if (done[u][k]) wn[u][k]++;
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         req[u] = 4'b0000;
         out_ready[u] = 1'b0;
         gap_on[u] = 1'b0;
         for (int k = 0; k < 4; k++) en[u][k] = 0;
      end
      qu0.delete();
      qu1.delete();
      step();
      step();
      clr_n = 1'b1;
   endtask

   // Keep requesting until the last expected word is being accepted, then drop req.
   task automatic drain(input int u, input int bound);
      int n;
      n = 0;
      while (!(done[u] != 4'b0000 && qsize(u) == 1) && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) chk("drain_timeout", 32'(qsize(u)), 32'd1);
      req[u] = 4'b0000;
      step();
      step();
      chk("back_to_idle", {27'd0, gnt[u], s2_clr[u]}, {27'd0, 4'b0000, 1'b1});
   endtask

   task automatic wait_valid(input int u, input string tag);
      int n;
      n = 0;
      while (!out_valid[u] && n < 10) begin
         step();
         n++;
      end
      chk(tag, {31'd0, out_valid[u]}, 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] g_hold;
      logic [7:0] d_hold;
      for (int u = 0; u < 2; u++) begin
         req[u] = 4'b0000;
         out_ready[u] = 1'b0;
      end
      #2;
      do_reset();

      // Reset: asynchronous abort while VALID with requester 2 granted
      chk("rst_s2_clr", {31'd0, s2_clr[0]}, 32'd1);
      req[0] = 4'b0100;
      out_ready[0] = 1'b0;
      wait_valid(0, "t1_reach_valid");
      chk("t1_gnt_pre", {28'd0, gnt[0]}, 32'h4);
      #2 clr_n = 1'b0;
      #1;
      chk("t1_gnt", {28'd0, gnt[0]}, 32'h0);
      chk("t1_valid", {31'd0, out_valid[0]}, 32'd0);
      chk("t1_clr", {31'd0, s2_clr[0]}, 32'd1);
      chk("t1_done", {28'd0, done[0]}, 32'h0);
      chk("t1_sel", {28'd0, A1[0], B1[0], A0[0], B0[0]}, 32'h0);
      req[0] = 4'b0000;
      step();
      step();
      clr_n = 1'b1;
      repeat (3) step();
      chk("t1_stay_idle", {26'd0, gnt[0], s2_clr[0], out_valid[0]}, {26'd0, 4'b0000, 1'b1, 1'b0});

      // Single word from requester 2
      out_ready[0] = 1'b1;
      req[0] = 4'b0100;
      push(0, 2);
      step();
      chk("t2_load_gnt", {28'd0, gnt[0]}, 32'h4);
      chk("t2_load_sel", {28'd0, A1[0], B1[0], A0[0], B0[0]}, 32'h8);
      chk("t2_load_flags", {30'd0, s2_clr[0], out_valid[0]}, 32'd0);
      step();
      chk("t2_valid", {31'd0, out_valid[0]}, 32'd1);
      chk("t2_done", {28'd0, done[0]}, 32'h4);
      chk("t2_word", {24'd0, s2q[0]}, 32'hA5);
      req[0] = 4'b0000;
      step();
      chk("t2_idle", {27'd0, gnt[0], s2_clr[0]}, {27'd0, 4'b0000, 1'b1});
      chk("t2_queue", 32'(qsize(0)), 32'd0);

      // Pure round-robin with MAX_BURST=1
      do_reset();
      gap_on[1] = 1'b1;
      out_ready[1] = 1'b1;
      req[1] = 4'b1111;
      push(1, 0); push(1, 1); push(1, 2); push(1, 3); push(1, 0);
      drain(1, 40);

      // Burst cap of 4 with requesters 1 and 3
      do_reset();
      gap_on[0] = 1'b1;
      out_ready[0] = 1'b1;
      req[0] = 4'b1010;
      for (int i = 0; i < 4; i++) push(0, 1);
      for (int i = 0; i < 4; i++) push(0, 3);
      push(0, 1);
      drain(0, 60);

      // Backpressure on requester 0
      gap_on[0] = 1'b0;
      out_ready[0] = 1'b0;
      req[0] = 4'b0001;
      push(0, 0);
      wait_valid(0, "t5_reach_valid");
      g_hold = gnt[0];
      d_hold = s2q[0];
      chk("t5_gnt", {28'd0, g_hold}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_hold", {22'd0, out_valid[0], gnt[0], A1[0], B1[0], A0[0], B0[0], done[0] != 4'b0000},
             {22'd0, 1'b1, g_hold, 4'b0000, 1'b0});
         chk("t5_word_stable", {24'd0, s2q[0]}, {24'd0, d_hold});
      end
      out_ready[0] = 1'b1;
      #1;
      chk("t5_done", {28'd0, done[0]}, 32'h1);
      req[0] = 4'b0000;
      step();
      chk("t5_single_pulse", {28'd0, done[0]}, 32'h0);
      step();

      // Withdrawal of requester 3 during LOAD
      out_ready[0] = 1'b1;
      req[0] = 4'b1000;
      push(0, 3);
      push(0, 1);
      step();
      chk("t6_load_gnt", {28'd0, gnt[0]}, 32'h8);
      req[0] = 4'b0010;
      drain(0, 20);

      chk("final_q0", 32'(qsize(0)), 32'd0);
      chk("final_q1", 32'(qsize(1)), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/s2_rr_sched.md
Name: s2_rr_sched

Overview:
- Round-robin scheduler that shares one s2 registered 4:1 select cell among four requesters (D0..D3 feed the s2 data inputs directly).
- Generates the s2 select pins (A1, B1, A0, B0) and the s2 synchronous clear.
- Presents the s2 register output to a single downstream consumer with a valid/ready handshake.
- Limits consecutive words per requester with a burst cap.

Parameters:
MAX_BURST, 4, maximum consecutive words granted to one requester before the scheduler rotates (legal range 1..(2^CW)-1).
CW, 4, width of the internal burst counter.

Ports:
clk  input  1  system clock, rising edge.
clr_n  input  1  asynchronous active-low reset.
req  input  4  per-requester request; req[k] means D_k holds a valid word.
gnt  output  4  one-hot grant; requester k holds D_k stable while gnt[k]=1.
done  output  4  one-cycle pulse; word from requester k accepted downstream.
A1  output  1  s2 select pin; S1 = A1|B1.
B1  output  1  s2 select pin, tied 0 by this block.
A0  output  1  s2 select pin; S0 = A0&B0.
B0  output  1  s2 select pin, driven equal to A0.
s2_clr  output  1  drives the s2 clr pin (synchronous, active-high).
out_valid  output  1  s2 register output holds an undelivered word.
out_ready  input  1  downstream accepts the word when out_valid=1.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE, gnt=0, done=0, out_valid=0, s2_clr=1, A1=B1=A0=B0=0.
  - ptr=0, burst_cnt=0.
  - The s2 register clears on each clk edge while reset is held.
- Select encoding for granted index k: A1=k[1], B1=0, A0=k[0], B0=k[0]. In IDLE all four pins are 0.
- IDLE:
  - gnt=0, out_valid=0, s2_clr=1.
  - If any req bit is set: winner = first set bit scanning ptr, ptr+1, ... (mod 4); gnt=onehot(winner) registered; burst_cnt=0; go to LOAD.
- LOAD (exactly 1 cycle):
  - gnt and select are driven, s2_clr=0, out_valid=0.
  - s2 captures D_k at the end of this cycle.
  - Go to VALID.
- VALID:
  - out_valid=1; gnt, select and s2_clr=0 held.
  - s2 reloads the same stable D_k each cycle.
  - If out_ready=0: remain in VALID with all outputs unchanged.
  - If out_ready=1:
    - done[k]=1 this cycle (combinational: VALID & out_ready, one-hot on k).
    - If req[k]=1 and burst_cnt+1 < MAX_BURST: burst_cnt+=1, go to LOAD with the same k. The requester must present its next word during that LOAD cycle.
    - Otherwise: ptr=(k+1) mod 4, then arbitrate over the current req. If any bit is set: new winner, burst_cnt=0, LOAD. If none: IDLE.
- Throughput: 2 cycles per word minimum. Latency from req to out_valid is 2 cycles from IDLE (one cycle in IDLE sampling req, one cycle in LOAD).
- Grant lock: once gnt[k] rises it stays until the word is accepted. If req[k] drops during LOAD or VALID, the word is still delivered; req[k] is only re-sampled at acceptance.
- Wrap-around: ptr increments mod 4 (3 -> 0). Requests not at ptr wait at most 3 rotations of MAX_BURST words each.
- MAX_BURST=1 gives pure round-robin. burst_cnt never exceeds MAX_BURST-1.
- Reset mid-transfer abandons the word: no done pulse, out_valid drops immediately.
- done and gnt are never asserted together with s2_clr=1.

Test Plan:
1. Reset: assert clr_n=0 during VALID with gnt=0100 -> gnt=0, out_valid=0, s2_clr=1, done=0, selects 0 immediately, without waiting for a clk edge; after release with req=0 -> stays IDLE.
2. Single word:
   - Stimulus: req=0100, D2=8'hA5, out_ready=1, req dropped after done.
   - Cycle 1: gnt=0100, A1=1, B1=0, A0=B0=0.
   - Cycle 2: out_valid=1, s2 out=8'hA5, done=0100.
   - Cycle 3: IDLE.
3. Round-robin, MAX_BURST=1:
   - Stimulus: req=1111 constant, out_ready=1.
   - Grant sequence 0001, 0010, 0100, 1000, 0001, with each grant lasting 2 cycles.
   - done pulses in the same order.
4. Burst cap, MAX_BURST=4:
   - Stimulus: req=1010 constant, out_ready=1, ptr=0.
   - Exactly 4 words granted to requester 1, then 4 to requester 3, then back to requester 1.
5. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles in VALID.
   - out_valid, gnt, selects and s2 output stay stable; no done.
   - Raising out_ready gives a single done pulse.
6. Withdrawal: req[3] drops during LOAD -> the word from D3 is still delivered with done=1000; requester 3 is then not re-granted.
